data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_if.sv | 25 ++
 rtl/data_memory_responder.sv | 161 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the core (master) and
// the memory responder (slave).
interface data_memory_responder_if #(
   parameter int BIT_COUNT = 32
);
   logic                 MemEn;
   logic                 MemWrite;
   logic [3:0]           ByteEn;
   logic [BIT_COUNT-1:0] MemAdr;
   logic [31:0]          MemWriteData;
   logic [31:0]          MemReadData;
   logic                 MemReady;
   logic                 MemStall;
   logic                 MemFault;

   modport master (
      output MemEn, MemWrite, ByteEn, MemAdr, MemWriteData,
      input  MemReadData, MemReady, MemStall, MemFault
   );

   modport slave (
      input  MemEn, MemWrite, ByteEn, MemAdr, MemWriteData,
      output MemReadData, MemReady, MemStall, MemFault
   );
endinterface

// File: rtl/data_memory_responder.sv
// Registered multi-cycle word memory answering the core's data port.
// Define MEM_PERF_COUNTERS_EN to add read/write/wait-cycle counters.
module data_memory_responder #(
   parameter int BIT_COUNT    = 32,
   parameter int MEMORY_WORDS = 100,
   parameter int WAIT_STATES  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   data_memory_responder_if.slave bus
`ifdef MEM_PERF_COUNTERS_EN
   ,
   output logic [31:0]            ReadCount,
   output logic [31:0]            WriteCount,
   output logic [31:0]            WaitCycleCount
`endif
);
   localparam int IW = BIT_COUNT - 2;
   localparam int AW = (MEMORY_WORDS > 1) ? $clog2(MEMORY_WORDS) : 1;
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   localparam logic [IW-1:0] LIMIT = IW'(MEMORY_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [3:0]    be_q, be_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   wd_q, wd_d;
   logic          fault_q, fault_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   mem_q [MEMORY_WORDS];

   logic [IW-1:0] req_idx;
   logic          ready;
   logic          stall;
   logic          commit;
   logic          unused_adr_lsb;

   assign req_idx        = bus.MemAdr[BIT_COUNT-1:2];
   assign unused_adr_lsb = ^bus.MemAdr[1:0];

   assign ready  = (state_q == S_RESP);
   assign stall  = bus.MemEn & ~ready;
   assign commit = ready & wr_q & ~fault_q & ~reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      be_d    = be_q;
      idx_d   = idx_q;
      wd_d    = wd_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.MemEn) begin
               wr_d    = bus.MemWrite;
               be_d    = bus.ByteEn;
               idx_d   = req_idx;
               wd_d    = bus.MemWriteData;
               fault_d = (req_idx >= LIMIT);
               cnt_d   = WS;
               state_d = (WS != 4'd0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            // a dropped request abandons the access entirely
            if (!bus.MemEn) begin
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = S_RESP;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // read data is captured on the edge entering RESPOND
      if (state_d == S_RESP && state_q != S_RESP) begin
         if (fault_d)
            rdata_d = 32'd0;
         else if (!wr_d)
            rdata_d = mem_q[idx_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         be_q    <= 4'd0;
         idx_q   <= '0;
         wd_q    <= 32'd0;
         fault_q <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         be_q    <= be_d;
         idx_q   <= idx_d;
         wd_q    <= wd_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i])
               mem_q[idx_q[AW-1:0]][8*i +: 8] <= wd_q[8*i +: 8];
         end
      end
   end

   assign bus.MemReady    = ready;
   assign bus.MemFault    = ready & fault_q;
   assign bus.MemStall    = stall;
   assign bus.MemReadData = rdata_q;

`ifdef MEM_PERF_COUNTERS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [31:0] wt_cnt_q, wt_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      wt_cnt_d = wt_cnt_q;
      if (ready && !fault_q) begin
         if (wr_q) wr_cnt_d = wr_cnt_q + 32'd1;
         else      rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (stall) wt_cnt_d = wt_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
         wt_cnt_q <= 32'd0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         wt_cnt_q <= wt_cnt_d;
      end
   end

   assign ReadCount      = rd_cnt_q;
   assign WriteCount     = wr_cnt_q;
   assign WaitCycleCount = wt_cnt_q;
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder: two instances
// (WAIT_STATES=2 and 0) checked every cycle against a transaction model.
module tb_data_memory_responder;
   localparam int BC = 32;
   localparam int MW = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        en = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  be = 4'd0;
   logic [31:0] adr = 32'd0;
   logic [31:0] wd = 32'd0;

   always #5 clk = ~clk;

   data_memory_responder_if #(.BIT_COUNT(BC)) if0 ();
   data_memory_responder_if #(.BIT_COUNT(BC)) if1 ();

   assign if0.MemEn        = en & ~sel;
   assign if0.MemWrite     = wr;
   assign if0.ByteEn       = be;
   assign if0.MemAdr       = adr;
   assign if0.MemWriteData = wd;
   assign if1.MemEn        = en & sel;
   assign if1.MemWrite     = wr;
   assign if1.ByteEn       = be;
   assign if1.MemAdr       = adr;
   assign if1.MemWriteData = wd;

`ifdef MEM_PERF_COUNTERS_EN
   logic [31:0] rc0, wc0, sc0, rc1, wc1, sc1;
`endif

   data_memory_responder #(
      .BIT_COUNT(BC), .MEMORY_WORDS(MW), .WAIT_STATES(2)
   ) u_ws2 (
      .clk(clk),
      .reset(reset),
      .bus(if0)
`ifdef MEM_PERF_COUNTERS_EN
      ,
      .ReadCount(rc0),
      .WriteCount(wc0),
      .WaitCycleCount(sc0)
`endif
   );

   data_memory_responder #(
      .BIT_COUNT(BC), .MEMORY_WORDS(MW), .WAIT_STATES(0)
   ) u_ws0 (
      .clk(clk),
      .reset(reset),
      .bus(if1)
`ifdef MEM_PERF_COUNTERS_EN
      ,
      .ReadCount(rc1),
      .WriteCount(wc1),
      .WaitCycleCount(sc1)
`endif
   );

   // transaction-level model
   logic [31:0] mem_m [2][MW];
   logic [31:0] rd_m [2];
   bit          e_rdy [2];
   bit          e_flt [2];
   bit          e_stl [2];
   int unsigned rc_m [2];
   int unsigned wc_m [2];
   int unsigned sc_m [2];

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;
   int cyc = 0;
   int xt0 = 0;
   int last_rdy = 0;
   bit last_flt = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ws_of(input bit s);
      return s ? 0 : 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ready0", {31'd0, if0.MemReady}, {31'd0, e_rdy[0]});
         chk("fault0", {31'd0, if0.MemFault}, {31'd0, e_flt[0]});
         chk("stall0", {31'd0, if0.MemStall}, {31'd0, e_stl[0]});
         chk("rdata0", if0.MemReadData, rd_m[0]);
         chk("ready1", {31'd0, if1.MemReady}, {31'd0, e_rdy[1]});
         chk("fault1", {31'd0, if1.MemFault}, {31'd0, e_flt[1]});
         chk("stall1", {31'd0, if1.MemStall}, {31'd0, e_stl[1]});
         chk("rdata1", if1.MemReadData, rd_m[1]);
`ifdef MEM_PERF_COUNTERS_EN
         chk("rdcnt0", rc0, rc_m[0]);
         chk("wrcnt0", wc0, wc_m[0]);
         chk("wtcnt0", sc0, sc_m[0]);
         chk("rdcnt1", rc1, rc_m[1]);
         chk("wrcnt1", wc1, wc_m[1]);
         chk("wtcnt1", sc1, sc_m[1]);
`endif
         if (if0.MemReady || if1.MemReady) begin
            last_rdy = cyc;
            last_flt = if0.MemReady ? if0.MemFault : if1.MemFault;
         end
         for (int s = 0; s < 2; s++)
            if (e_stl[s]) sc_m[s]++;
      end
   end

   task automatic clear_exp();
      en = 1'b0;
      for (int s = 0; s < 2; s++) begin
         e_rdy[s] = 1'b0;
         e_flt[s] = 1'b0;
         e_stl[s] = 1'b0;
      end
   endtask

   // one reset cycle; returns at the start of the following cycle
   task automatic rst_cycle();
      clear_exp();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         rd_m[s] = 32'd0;
         rc_m[s] = 0;
         wc_m[s] = 0;
         sc_m[s] = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         clear_exp();
         @(posedge clk);
         #1;
      end
   endtask

   // ab: cycle (1..ws) where MemEn drops, 0 for none; rs: reset instead
   task automatic xact(input bit s, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input int ab, input bit rs);
      int ws;
      int ix;
      bit oor;
      ws  = ws_of(s);
      ix  = int'(a[31:2]);
      oor = (ix >= MW);
      xt0 = cyc;
      sel = s;
      en  = 1'b1;
      wr  = w;
      be  = b;
      adr = a;
      wd  = d;
      e_rdy[s] = 1'b0;
      e_flt[s] = 1'b0;
      e_stl[s] = 1'b1;
      for (int k = 1; k <= ws + 1; k++) begin
         @(posedge clk);
         #1;
         wr  = 1'($urandom);
         be  = 4'($urandom);
         adr = $urandom;
         wd  = $urandom;
         if (ab == k) begin
            if (rs) begin
               rst_cycle();
            end else begin
               en = 1'b0;
               e_stl[s] = 1'b0;
               @(posedge clk);
               #1;
            end
            return;
         end
         if (k == ws + 1) begin
            e_rdy[s] = 1'b1;
            e_flt[s] = oor;
            e_stl[s] = 1'b0;
            if (oor) rd_m[s] = 32'd0;
            else if (!w) rd_m[s] = mem_m[s][ix];
         end
      end
      @(posedge clk);
      #1;
      if (!oor) begin
         if (w) begin
            for (int i = 0; i < 4; i++)
               if (b[i]) mem_m[s][ix][8*i +: 8] = d[8*i +: 8];
            wc_m[s]++;
         end else begin
            rc_m[s]++;
         end
      end
      clear_exp();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r1;
      int ab;
      bit s;
      logic [31:0] a;
      clear_exp();
      for (int s2 = 0; s2 < 2; s2++) begin
         rd_m[s2] = 32'd0;
         rc_m[s2] = 0;
         wc_m[s2] = 0;
         sc_m[s2] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_on = 1'b1;
      chk("rst_rdata", if0.MemReadData, 32'd0);
      chk("rst_ready", {31'd0, if0.MemReady}, 32'd0);

      // give every word a known value
      for (int s2 = 0; s2 < 2; s2++)
         for (int w = 0; w < MW; w++)
            xact(1'(s2), 1'b1, 4'hF, 32'(w * 4), $urandom, 0, 1'b0);
      rst_cycle();

      xact(0, 1, 4'hF, 32'h8, 32'hDEADBEEF, 0, 0);
      chk("lat_ws2", 32'(last_rdy - xt0), 32'd3);
      xact(0, 0, 4'hF, 32'h8, 32'h0, 0, 0);
      chk("rd_full", if0.MemReadData, 32'hDEADBEEF);
      xact(0, 1, 4'b0010, 32'h8, 32'h0000AA00, 0, 0);
      xact(0, 0, 4'h0, 32'h8, 32'h0, 0, 0);
      chk("rd_lane", if0.MemReadData, 32'hDEADAAEF);
      xact(0, 0, 4'hF, 32'hB, 32'h0, 0, 0);
      chk("rd_lsb", if0.MemReadData, 32'hDEADAAEF);
`ifdef MEM_PERF_COUNTERS_EN
      chk("perf_rd", rc0, 32'd3);
      chk("perf_wr", wc0, 32'd2);
      chk("perf_wt", sc0, 32'd15);
`endif
      xact(0, 1, 4'h0, 32'h8, 32'hFFFFFFFF, 0, 0);
      xact(0, 0, 4'hF, 32'h8, 32'h0, 0, 0);
      chk("be_zero", if0.MemReadData, 32'hDEADAAEF);

      xact(0, 0, 4'hF, 32'h190, 32'h0, 0, 0);
      chk("flt_flag", {31'd0, last_flt}, 32'd1);
      chk("flt_rdata", if0.MemReadData, 32'd0);
      xact(0, 1, 4'hF, 32'h190, 32'h11111111, 0, 0);

      xact(0, 1, 4'hF, 32'h4, 32'h55AA55AA, 0, 0);
      xact(0, 1, 4'hF, 32'h4, 32'h12345678, 1, 0);
      xact(0, 0, 4'hF, 32'h4, 32'h0, 0, 0);
      chk("abort_keep", if0.MemReadData, 32'h55AA55AA);
      xact(0, 1, 4'hF, 32'h4, 32'h12345678, 2, 1);
      chk("rst_clear", if0.MemReadData, 32'd0);
      xact(0, 0, 4'hF, 32'h4, 32'h0, 0, 0);
      chk("rst_keep", if0.MemReadData, 32'h55AA55AA);

      idle(1);
      xact(1, 0, 4'hF, 32'h0, 32'h0, 0, 0);
      chk("lat_ws0", 32'(last_rdy - xt0), 32'd1);
      r1 = last_rdy;
      xact(1, 0, 4'hF, 32'h4, 32'h0, 0, 0);
      chk("b2b_gap", 32'(last_rdy - r1), 32'd2);

      for (int n = 0; n < 400; n++) begin
         s = 1'($urandom);
         if ($urandom_range(0, 9) == 0)
            a = 32'($urandom_range(MW, MW + 40) * 4);
         else
            a = 32'($urandom_range(0, MW - 1) * 4);
         a = a + 32'($urandom_range(0, 3));
         ab = 0;
         if (ws_of(s) > 0 && $urandom_range(0, 7) == 0)
            ab = $urandom_range(1, ws_of(s));
         xact(s, 1'($urandom), 4'($urandom), a, $urandom, ab,
              ab != 0 && $urandom_range(0, 3) == 0);
         idle($urandom_range(0, 2));
      end

      idle(2);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
